// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pixel pipeline:
//   - mode_t : runtime output mode (BLACK, BORDER, CAMERA, BARS)
//   - DEF_*  : default 640x480 visible-window timing constants
//   - col_*  : colour helpers. They return 32-bit values; callers truncate
//              to their own pixel width CW.
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK  = 2'd0,
    MODE_BORDER = 2'd1,
    MODE_CAMERA = 2'd2,
    MODE_BARS   = 2'd3
  } mode_t;

  localparam int DEF_H_START = 160;
  localparam int DEF_H_END   = 800;
  localparam int DEF_V_START = 41;
  localparam int DEF_V_END   = 521;

  // White: all CW bits set.
  function automatic logic [31:0] col_white(input int cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

  // Red: only the MSB of a CW-bit pixel is set.
  function automatic logic [31:0] col_red(input int cw);
    return 32'd1 << (cw - 1);
  endfunction

  // Bar colour: the 3-bit bar index goes in the top 3 bits, and the low bits are 0.
  // The caller must use cw >= 3.
  function automatic logic [31:0] col_bar(input logic [2:0] idx, input int cw);
    return 32'(idx) << (cw - 3);
  endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// -----------------------------------------------------------------------------
// vga_pixel_fifo
// Show-ahead prefetch FIFO for frame-buffer pixels.
// Parameters: DEPTH (power of two, >= 4), CW (word width).
// Ports:
//   clk, rst   clock, asynchronous active-high reset (pointers only)
//   push, din  write strobe and data. The FIFO drops the word when it is full.
//   pop, dout  read strobe and head-of-queue data. dout is valid while !empty.
//   flush      resets both pointers. It takes priority over push and pop.
//   fill       number of stored words (0..DEPTH)
//   empty      high when fill is 0
//   full       high when fill equals DEPTH
// -----------------------------------------------------------------------------
module vga_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [CW-1:0]            din,
  input  logic                     pop,
  output logic [CW-1:0]            dout,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          w_wr_en;
  logic          w_rd_en;

  // Pointers carry one extra wrap bit, so fill can tell full from empty.
  assign fill    = r_wr - r_rd;
  assign empty   = (fill == '0);
  assign full    = (fill == (AW+1)'(DEPTH));
  assign dout    = r_mem[r_rd[AW-1:0]];
  assign w_wr_en = push && !full && !flush;
  assign w_rd_en = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_rd_en) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_pixel_pipe.sv
// -----------------------------------------------------------------------------
// vga_pixel_pipe
// Generates registered CW-bit RGB from the VGA sync counters in one of four
// modes. In CAMERA mode, pixels come from a frame-buffer reader through a
// prefetch FIFO.
// Configuration macro: VGA_PIPE_BARS_EN. When it is defined, the colour-bar
// generator exists. When it is undefined, mode 3 outputs black.
// Ports:
//   clk_25, reset          pixel clock, asynchronous active-high reset
//   h_count, v_count       sync counters
//   bright                 visible-area flag
//   mode                   0 BLACK, 1 BORDER, 2 CAMERA, 3 BARS
//   read                   pixel request to the frame-buffer reader
//   data, data_valid       returned pixel and its qualifier
//   rgb                    registered pixel output
//   sof                    one-cycle pulse after h_count = v_count = 0
//   underflow              sticky flag for a CAMERA pixel taken from an empty FIFO
//   underflow_clr          clears underflow. A new underflow in the same cycle wins.
// -----------------------------------------------------------------------------
module vga_pixel_pipe
  import vga_pkg::*;
#(
  parameter int CW      = 3,
  parameter int DEPTH   = 16,
  parameter int H_START = DEF_H_START,
  parameter int H_END   = DEF_H_END,
  parameter int V_START = DEF_V_START,
  parameter int V_END   = DEF_V_END,
  parameter int BORDER  = 10
) (
  input  logic          clk_25,
  input  logic          reset,
  input  logic [9:0]    h_count,
  input  logic [9:0]    v_count,
  input  logic          bright,
  input  logic [1:0]    mode,
  output logic          read,
  input  logic [CW-1:0] data,
  input  logic          data_valid,
  output logic [CW-1:0] rgb,
  output logic          sof,
  output logic          underflow,
  input  logic          underflow_clr
);

  localparam int            FW      = $clog2(DEPTH) + 1;
  localparam logic [9:0]    HB_LO   = 10'(H_START + BORDER);
  localparam logic [9:0]    HB_HI   = 10'(H_END - BORDER);
  localparam logic [9:0]    VB_LO   = 10'(V_START + BORDER);
  localparam logic [9:0]    VB_HI   = 10'(V_END - BORDER);
  localparam logic [CW-1:0] C_WHITE = CW'(col_white(CW));
  localparam logic [CW-1:0] C_RED   = CW'(col_red(CW));

  logic [CW-1:0] r_rgb;
  logic          r_read;
  logic          r_sof;
  logic          r_uf;
  logic [3:0]    r_out;    // requests still waiting for data_valid
  logic [3:0]    r_disc;   // returns still to be dropped after a flush

  mode_t         w_mode;
  logic          w_camera;
  logic          w_sof_det;
  logic          w_flush;
  logic          w_dv_ok;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_uf_set;
  logic [3:0]    w_out_nxt;
  logic [3:0]    w_disc_nxt;
  logic [FW-1:0] w_fill;
  logic [FW-1:0] w_fill_nxt;
  logic [FW:0]   w_sum;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_dout;
  logic          w_read_nxt;
  logic [CW-1:0] w_pix;
  logic          w_border;

  assign w_mode    = mode_t'(mode);
  assign w_camera  = (w_mode == MODE_CAMERA);
  assign w_sof_det = (h_count == 10'd0) && (v_count == 10'd0);
  assign w_flush   = r_sof;

  // A return arriving while nothing is outstanding is a leftover from before
  // a reset. It is ignored.
  assign w_dv_ok  = data_valid && (r_out != 4'd0);
  assign w_drop   = w_dv_ok && (w_flush || (r_disc != 4'd0));
  assign w_push   = w_dv_ok && !w_drop;
  assign w_pop    = bright && w_camera && !w_empty && !w_flush;
  assign w_uf_set = bright && w_camera && w_empty;

  assign w_out_nxt  = r_out + {3'd0, r_read} - {3'd0, w_dv_ok};
  // At the flush, every request still in flight becomes a return to discard.
  // A return that arrives in the flush cycle itself is dropped immediately.
  assign w_disc_nxt = w_flush ? (r_out - {3'd0, w_dv_ok})
                              : (r_disc - {3'd0, w_drop});
  assign w_fill_nxt = w_flush ? '0
                              : (w_fill + FW'(w_push && !w_full) - FW'(w_pop));
  assign w_sum      = {1'b0, w_fill_nxt} + (FW+1)'(w_out_nxt);

  // read is registered, so the request decision uses next-cycle occupancy.
  // This keeps fill + outstanding from ever exceeding DEPTH.
  assign w_read_nxt = w_camera && !w_sof_det && (w_disc_nxt == 4'd0) &&
                      (w_out_nxt != 4'hF) && (w_sum < (FW+1)'(DEPTH));

  vga_pixel_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk_25),
    .rst   (reset),
    .push  (w_push),
    .din   (data),
    .pop   (w_pop),
    .dout  (w_dout),
    .flush (w_flush),
    .fill  (w_fill),
    .empty (w_empty),
    .full  (w_full)
  );

  assign w_border = (h_count < HB_LO) || (h_count >= HB_HI) ||
                    (v_count < VB_LO) || (v_count >= VB_HI);

`ifdef VGA_PIPE_BARS_EN
  localparam int BAR_W = (H_END - H_START) / 8;
  logic [2:0] w_bar_idx;

  // The bar index comes from comparisons against constant boundaries, so no divider is needed.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_count >= 10'(H_START + k * BAR_W)) w_bar_idx = 3'(k);
    end
  end
`endif

  always_comb begin
    w_pix = '0;
    if (bright) begin
      case (w_mode)
        MODE_BORDER: w_pix = w_border ? C_RED : C_WHITE;
        MODE_CAMERA: w_pix = w_empty ? C_RED : w_dout;
        MODE_BARS: begin
`ifdef VGA_PIPE_BARS_EN
          w_pix = CW'(col_bar(w_bar_idx, CW));
`else
          w_pix = '0;
`endif
        end
        default: w_pix = '0;
      endcase
    end
  end

  // ---- output and control registers ----
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      r_rgb  <= '0;
      r_read <= 1'b0;
      r_sof  <= 1'b0;
      r_uf   <= 1'b0;
      r_out  <= 4'd0;
      r_disc <= 4'd0;
    end else begin
      r_rgb  <= w_pix;
      r_read <= w_read_nxt;
      r_sof  <= w_sof_det;
      r_out  <= w_out_nxt;
      r_disc <= w_disc_nxt;
      if (w_uf_set)           r_uf <= 1'b1;
      else if (underflow_clr) r_uf <= 1'b0;
    end
  end

  assign rgb       = r_rgb;
  assign read      = r_read;
  assign sof       = r_sof;
  assign underflow = r_uf;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
module tb_vga_pixel_pipe;

  logic       clk_25 = 1'b0;
  logic       reset;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       bright;
  logic [1:0] mode;
  logic       read;
  logic [2:0] data;
  logic       data_valid;
  logic [2:0] rgb;
  logic       sof;
  logic       underflow;
  logic       underflow_clr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [2:0] exp_q[$];    // scoreboard: expected rgb per driven cycle
  logic [2:0] exp_cam[$];  // returned words expected to reach the FIFO
  int         pend[$];     // reader model: due cycle for each accepted read

  int   cyc      = 0;
  int   lat      = 5;
  int   drop_n   = 0;
  int   word_ctr = 0;
  bit   hold     = 1'b0;
  bit   sof_pend = 1'b0;
  logic exp_uf   = 1'b0;

  vga_pixel_pipe dut (
    .clk_25        (clk_25),
    .reset         (reset),
    .h_count       (h_count),
    .v_count       (v_count),
    .bright        (bright),
    .mode          (mode),
    .read          (read),
    .data          (data),
    .data_valid    (data_valid),
    .rgb           (rgb),
    .sof           (sof),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  always #20 clk_25 = ~clk_25;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs, updates the reference model, then compares
  // the registered outputs just after the clock edge.
  task automatic step(input int h, input int v, input logic b, input logic [1:0] m,
                      input logic clr);
    logic [2:0] e;
    logic [2:0] w;
    logic       starve;
    h_count       = 10'(h);
    v_count       = 10'(v);
    bright        = b;
    mode          = m;
    underflow_clr = clr;
    cyc++;
    e      = 3'd0;
    starve = 1'b0;
    if (reset) begin
      drop_n   = pend.size();
      exp_cam.delete();
      sof_pend = 1'b0;
    end else begin
      if (sof_pend) begin
        drop_n = pend.size();
        exp_cam.delete();
      end
      sof_pend = (h == 0) && (v == 0);
      if (b) begin
        case (m)
          2'd1: e = (h < 170 || h >= 790 || v < 51 || v >= 511) ? 3'b100 : 3'b111;
          2'd2: begin
            if (exp_cam.size() > 0) e = exp_cam.pop_front();
            else begin
              e      = 3'b100;
              starve = 1'b1;
            end
          end
          2'd3: begin
`ifdef VGA_PIPE_BARS_EN
            e = 3'((h - 160) / 80);
`else
            e = 3'd0;
`endif
          end
          default: e = 3'd0;
        endcase
      end
    end
    if (reset)            exp_uf = 1'b0;
    else if (starve)      exp_uf = 1'b1;
    else if (clr)         exp_uf = 1'b0;
    exp_q.push_back(e);

    data_valid = 1'b0;
    if (!hold && pend.size() > 0 && pend[0] <= cyc) begin
      void'(pend.pop_front());
      w = 3'(word_ctr);
      word_ctr++;
      data       = w;
      data_valid = 1'b1;
      if (drop_n > 0) drop_n--;
      else            exp_cam.push_back(w);
    end
    if (read && !reset) pend.push_back(cyc + lat);

    @(posedge clk_25);
    #1;
    chk("rgb", 32'(rgb), 32'(exp_q.pop_front()));
    chk("sof", 32'(sof), 32'(sof_pend));
    chk("underflow", 32'(underflow), 32'(exp_uf));
  endtask

  int bh[8] = '{165, 400, 400, 789, 790, 400, 400, 170};
  int bv[8] = '{100, 200, 200, 300, 300,  50, 511, 100};
  bit bb[8] = '{1,   1,   0,   1,   1,   1,   1,   1};
  int n;

  initial begin
    reset         = 1'b1;
    h_count       = 10'd10;
    v_count       = 10'd30;
    bright        = 1'b0;
    mode          = 2'd0;
    data          = 3'd0;
    data_valid    = 1'b0;
    underflow_clr = 1'b0;

    step(10, 30, 0, 2'd2, 0);
    step(10, 30, 0, 2'd2, 0);
    chk("reset_read", 32'(read), 32'd0);
    reset = 1'b0;
    step(10, 30, 0, 2'd0, 0);

    // BORDER mode: corners, edges, interior and bright = 0
    for (int i = 0; i < 8; i++) step(bh[i], bv[i], bb[i], 2'd1, 0);
    step(400, 200, 1, 2'd0, 0);

    // BARS: start and end of each bar
    for (int i = 0; i < 8; i++) begin
      step(160 + 80 * i, 200, 1, 2'd3, 0);
      step(160 + 80 * i + 79, 200, 1, 2'd3, 0);
    end
    step(400, 200, 0, 2'd3, 0);

    // Reset mid-frame with 3 requests in flight
    n = 0;
    while (pend.size() < 3 && n < 10) begin
      step(10, 30, 0, 2'd2, 0);
      n++;
    end
    chk("out_before_reset", 32'(dut.r_out), 32'd3);
    reset = 1'b1;
    #1;
    chk("arst_rgb", 32'(rgb), 32'd0);
    chk("arst_read", 32'(read), 32'd0);
    chk("arst_sof", 32'(sof), 32'd0);
    chk("arst_underflow", 32'(underflow), 32'd0);
    step(10, 30, 0, 2'd0, 0);
    step(10, 30, 0, 2'd0, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(10, 30, 0, 2'd0, 0);
    chk("late_dv_fill", 32'(dut.u_fifo.fill), 32'd0);
    chk("late_dv_out", 32'(dut.r_out), 32'd0);
    chk("late_dv_read", 32'(read), 32'd0);

    // CAMERA: prefill, then a full visible line at latency 5
    for (int i = 0; i < 40; i++) step(10, 30, 0, 2'd2, 0);
    chk("prefill_fill", 32'(dut.u_fifo.fill), 32'd16);
    for (int i = 0; i < 640; i++) step(160 + i, 100, 1, 2'd2, 0);
    chk("line_no_underflow", 32'(underflow), 32'd0);

    // Starvation; the clear at k = 30 collides with a new underflow
    hold = 1'b1;
    for (int k = 0; k < 40; k++) step(160 + k, 101, 1, 2'd2, (k == 30));
    hold = 1'b0;
    step(10, 30, 0, 2'd2, 1);

    // Frame resync with requests in flight
    n = 0;
    while (pend.size() != 5 && n < 40) begin
      step(10, 30, 0, 2'd0, 0);
      n++;
    end
    step(0, 0, 0, 2'd0, 0);
    step(10, 30, 0, 2'd2, 0);
    chk("sof_discard", 32'(dut.r_disc), 32'(drop_n));
    chk("sof_fill", 32'(dut.u_fifo.fill), 32'd0);
    n = 0;
    while (drop_n > 0 && n < 20) begin
      step(10, 30, 0, 2'd2, 0);
      if (drop_n > 0) chk("read_blocked", 32'(read), 32'd0);
      n++;
    end
    n = 0;
    while (read !== 1'b1 && n < 4) begin
      step(10, 30, 0, 2'd2, 0);
      n++;
    end
    chk("read_resume", 32'(read), 32'd1);
    for (int i = 0; i < 30; i++) step(10, 30, 0, 2'd2, 0);
    for (int i = 0; i < 20; i++) step(160 + i, 102, 1, 2'd2, 0);
    chk("post_sof_underflow", 32'(underflow), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
